// File: rtl/srg_multicycle_control.sv
// srg_multicycle_control: multicycle MIPS control FSM driving the ALU and datapath selects/enables.
// Walks each instruction through FETCH, DECODE and its execute/memory/writeback states,
// and stalls in the memory states until MemReady.
// Optional feature macro: SRG_CTRL_BNE_EN adds bne, which reuses BEQEX with an inverted Zero test.
module srg_multicycle_control #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [5:0] Opcode,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       MemReady,
    output logic [2:0] OperationSelect,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic [1:0] PCSrc,
    output logic       PCEn,
    output logic       Illegal,
    output logic       MemTimeout,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef SRG_CTRL_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [15:0] TIMEOUT_LIMIT = 16'(MEM_TIMEOUT);

    state_t      state;
    state_t      next_state;
    logic [15:0] wait_count;
    logic        waiting;
    logic        branch_cond;

    logic        pc_write;
    logic        branch;
    logic        ir_write_raw;
    logic        mem_write_raw;
    logic        reg_write_raw;
    logic        illegal_raw;

    // State register; reset and any unknown encoding both land in FETCH.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

`ifdef SRG_CTRL_BNE_EN
    logic not_equal;

    // Remember in DECODE whether this branch is a bne so BEQEX inverts the Zero test.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            not_equal <= 1'b0;
        end else if (state == DECODE) begin
            not_equal <= (Opcode == OP_BNE);
        end
    end

    assign branch_cond = not_equal ? ~Zero : Zero;
`else
    assign branch_cond = Zero;
`endif

    assign waiting = ((state == FETCH) || (state == MEMRD) || (state == MEMWR)) && !MemReady;

    // Count consecutive stalled memory cycles; the sticky flag sets the cycle the limit is reached.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            wait_count <= 16'd0;
            MemTimeout <= 1'b0;
        end else if (waiting) begin
            if (wait_count < TIMEOUT_LIMIT) begin
                wait_count <= wait_count + 16'd1;
            end
            if (wait_count >= TIMEOUT_LIMIT - 16'd1) begin
                MemTimeout <= 1'b1;
            end
        end else begin
            wait_count <= 16'd0;
        end
    end

    // Next-state decode and Moore outputs, with MemReady qualifying the fetch enables.
    always_comb begin
        next_state      = FETCH;
        OperationSelect = ALU_ADD;
        ALUSrcA         = 1'b0;
        ALUSrcB         = 2'b00;
        IorD            = 1'b0;
        RegDst          = 1'b0;
        MemtoReg        = 1'b0;
        PCSrc           = 2'b00;
        pc_write        = 1'b0;
        branch          = 1'b0;
        ir_write_raw    = 1'b0;
        mem_write_raw   = 1'b0;
        reg_write_raw   = 1'b0;
        illegal_raw     = 1'b0;
        case (state)
            FETCH: begin
                ALUSrcB      = 2'b01;
                ir_write_raw = MemReady;
                pc_write     = MemReady;
                next_state   = MemReady ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                case (Opcode)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_RTYPE: begin
                        if ((Funct == FN_ADD) || (Funct == FN_SUB) || (Funct == FN_AND) ||
                            (Funct == FN_OR) || (Funct == FN_SLT)) begin
                            next_state = RTYPEEX;
                        end else begin
                            illegal_raw = 1'b1;
                            next_state  = FETCH;
                        end
                    end
                    OP_BEQ:  next_state = BEQEX;
`ifdef SRG_CTRL_BNE_EN
                    OP_BNE:  next_state = BEQEX;
`endif
                    OP_ADDI: next_state = ADDIEX;
                    OP_J:    next_state = JEX;
                    default: begin
                        illegal_raw = 1'b1;
                        next_state  = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                next_state = (Opcode == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                IorD       = 1'b1;
                next_state = MemReady ? MEMWB : MEMRD;
            end
            MEMWB: begin
                MemtoReg      = 1'b1;
                reg_write_raw = 1'b1;
                next_state    = FETCH;
            end
            MEMWR: begin
                IorD          = 1'b1;
                mem_write_raw = 1'b1;
                next_state    = MemReady ? FETCH : MEMWR;
            end
            RTYPEEX: begin
                ALUSrcA = 1'b1;
                case (Funct)
                    FN_SUB:  OperationSelect = ALU_SUB;
                    FN_AND:  OperationSelect = ALU_AND;
                    FN_OR:   OperationSelect = ALU_OR;
                    FN_SLT:  OperationSelect = ALU_SLT;
                    default: OperationSelect = ALU_ADD;
                endcase
                next_state = RTYPEWB;
            end
            RTYPEWB: begin
                RegDst        = 1'b1;
                reg_write_raw = 1'b1;
                next_state    = FETCH;
            end
            BEQEX: begin
                ALUSrcA         = 1'b1;
                OperationSelect = ALU_SUB;
                PCSrc           = 2'b01;
                branch          = 1'b1;
                next_state      = FETCH;
            end
            ADDIEX: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                next_state = ADDIWB;
            end
            ADDIWB: begin
                reg_write_raw = 1'b1;
                next_state    = FETCH;
            end
            JEX: begin
                PCSrc      = 2'b10;
                pc_write   = 1'b1;
                next_state = FETCH;
            end
            default: next_state = FETCH;
        endcase
    end

    assign PCEn     = (pc_write | (branch & branch_cond)) & ~Reset;
    assign IRWrite  = ir_write_raw & ~Reset;
    assign MemWrite = mem_write_raw & ~Reset;
    assign RegWrite = reg_write_raw & ~Reset;
    assign Illegal  = illegal_raw & ~Reset;
    assign State    = state;

endmodule

// File: tb/tb_srg_multicycle_control.sv
// tb_srg_multicycle_control: directed scoreboard bench for the multicycle control FSM.
// Every stimulus cycle pushes the hand-derived expected output word; a negedge monitor pops and compares.
module tb_srg_multicycle_control;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [5:0] Opcode;
    logic [5:0] Funct;
    logic       Zero;
    logic       MemReady;
    logic [2:0] OperationSelect;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       IorD;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic [1:0] PCSrc;
    logic       PCEn;
    logic       Illegal;
    logic       MemTimeout;
    logic [3:0] State;

    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] BNE  = 6'b000101;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] JMP  = 6'b000010;
    localparam logic [5:0] BAD  = 6'b111111;
    localparam logic [5:0] SLT  = 6'b101010;
    localparam logic [5:0] NOFN = 6'b000000;

    typedef struct {
        string       name;
        logic [20:0] exp;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic [20:0] act;

    srg_multicycle_control #(.MEM_TIMEOUT(4)) dut (
        .Clock(Clock), .Reset(Reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
        .MemReady(MemReady), .OperationSelect(OperationSelect), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .PCSrc(PCSrc),
        .PCEn(PCEn), .Illegal(Illegal), .MemTimeout(MemTimeout), .State(State)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 Clock = ~Clock;

    assign act = {State, OperationSelect, ALUSrcA, ALUSrcB, IorD, MemWrite, IRWrite,
                  RegWrite, RegDst, MemtoReg, PCSrc, PCEn, Illegal, MemTimeout};

    // Field order: state, opsel, srcA, srcB, IorD, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg, PCSrc, PCEn, Illegal, MemTimeout.
    function automatic logic [20:0] vec(input logic [3:0] st, input logic [2:0] op, input logic sa,
                                        input logic [1:0] sbsel, input logic iord, input logic mw,
                                        input logic irw, input logic rw, input logic rd,
                                        input logic m2r, input logic [1:0] pcs, input logic pcen,
                                        input logic ill, input logic mto);
        return {st, op, sa, sbsel, iord, mw, irw, rw, rd, m2r, pcs, pcen, ill, mto};
    endfunction

    // Drive one cycle of inputs shortly after the rising edge.
    task automatic applyStimulus(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                                 input logic z, input logic mr);
        @(posedge Clock);
        #1;
        Reset    = rst;
        Opcode   = op;
        Funct    = fn;
        Zero     = z;
        MemReady = mr;
    endtask

    // Queue the expected output word for the cycle just driven.
    task automatic checkOutput(input string name, input logic [20:0] exp);
        exp_t e;
        e.name = name;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    task automatic step(input string name, input logic rst, input logic [5:0] op, input logic [5:0] fn,
                        input logic z, input logic mr, input logic [20:0] exp);
        applyStimulus(rst, op, fn, z, mr);
        checkOutput(name, exp);
    endtask

    // Monitor: compare the DUT outputs against the oldest queued expectation each falling edge.
    always @(negedge Clock) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            checks = checks + 1;
            if (act !== e.exp) begin
                failures = failures + 1;
                $display("[TB] FAIL %s: got %b expected %b", e.name, act, e.exp);
            end
        end
    end

    initial begin
        Reset    = 1'b1;
        Opcode   = RT;
        Funct    = SLT;
        Zero     = 1'b0;
        MemReady = 1'b1;

        // Reset held two cycles: FETCH outputs with all enables suppressed.
        step("rst_cycle1",  1, RT, SLT, 0, 1, vec(0, 3'b010, 0, 2'b01, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0));
        step("rst_cycle2",  1, RT, SLT, 0, 1, vec(0, 3'b010, 0, 2'b01, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0));
        @(negedge Clock);
        checks = checks + 1;
        if ((State !== 4'd0) || (MemTimeout !== 1'b0) || (PCEn !== 1'b0) || (IRWrite !== 1'b0) ||
            (MemWrite !== 1'b0) || (RegWrite !== 1'b0) || (Illegal !== 1'b0)) begin
            failures = failures + 1;
            $display("[TB] FAIL reset_state: State=%0d MemTimeout=%b PCEn=%b IRWrite=%b MemWrite=%b RegWrite=%b Illegal=%b",
                     State, MemTimeout, PCEn, IRWrite, MemWrite, RegWrite, Illegal);
        end
        step("fetch_first", 0, RT, SLT, 0, 1, vec(0, 3'b010, 0, 2'b01, 0, 0, 1, 0, 0, 0, 2'b00, 1, 0, 0));

        // R-type slt.
        step("rt_decode",   0, RT, SLT, 0, 1, vec(1, 3'b010, 0, 2'b11, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0));
        step("rt_exec_slt", 0, RT, SLT, 0, 1, vec(6, 3'b111, 1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0));
        step("rt_wb",       0, RT, SLT, 0, 1, vec(7, 3'b010, 0, 2'b00, 0, 0, 0, 1, 1, 0, 2'b00, 0, 0, 0));

        // lw with three stall cycles in MEMRD.
        step("lw_fetch",    0, LW, NOFN, 0, 1, vec(0, 3'b010, 0, 2'b01, 0, 0, 1, 0, 0, 0, 2'b00, 1, 0, 0));
        step("lw_decode",   0, LW, NOFN, 0, 1, vec(1, 3'b010, 0, 2'b11, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0));
        step("lw_memadr",   0, LW, NOFN, 0, 1, vec(2, 3'b010, 1, 2'b10, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0));
        for (int i = 0; i < 4; i++) begin
            step($sformatf("lw_memrd%0d", i), 0, LW, NOFN, 0, (i == 3),
                 vec(3, 3'b010, 0, 2'b00, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0));
        end
        step("lw_memwb",    0, LW, NOFN, 0, 1, vec(4, 3'b010, 0, 2'b00, 0, 0, 0, 1, 0, 1, 2'b00, 0, 0, 0));

        // sw with MemWrite held through three stall cycles.
        step("sw_fetch",    0, SW, NOFN, 0, 1, vec(0, 3'b010, 0, 2'b01, 0, 0, 1, 0, 0, 0, 2'b00, 1, 0, 0));
        step("sw_decode",   0, SW, NOFN, 0, 1, vec(1, 3'b010, 0, 2'b11, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0));
        step("sw_memadr",   0, SW, NOFN, 0, 1, vec(2, 3'b010, 1, 2'b10, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0));
        for (int i = 0; i < 4; i++) begin
            step($sformatf("sw_memwr%0d", i), 0, SW, NOFN, 0, (i == 3),
                 vec(5, 3'b010, 0, 2'b00, 1, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0));
        end

        // beq taken, then not taken.
        step("beq1_fetch",  0, BEQ, NOFN, 1, 1, vec(0, 3'b010, 0, 2'b01, 0, 0, 1, 0, 0, 0, 2'b00, 1, 0, 0));
        step("beq1_decode", 0, BEQ, NOFN, 1, 1, vec(1, 3'b010, 0, 2'b11, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0));
        step("beq_taken",   0, BEQ, NOFN, 1, 1, vec(8, 3'b110, 1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b01, 1, 0, 0));
        step("beq2_fetch",  0, BEQ, NOFN, 0, 1, vec(0, 3'b010, 0, 2'b01, 0, 0, 1, 0, 0, 0, 2'b00, 1, 0, 0));
        step("beq2_decode", 0, BEQ, NOFN, 0, 1, vec(1, 3'b010, 0, 2'b11, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0));
        step("beq_not_taken", 0, BEQ, NOFN, 0, 1, vec(8, 3'b110, 1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0));

        // Undecodable opcode: a single Illegal pulse in DECODE, then straight back to FETCH.
        step("bad_fetch",   0, BAD, NOFN, 0, 1, vec(0, 3'b010, 0, 2'b01, 0, 0, 1, 0, 0, 0, 2'b00, 1, 0, 0));
        step("bad_decode",  0, BAD, NOFN, 0, 1, vec(1, 3'b010, 0, 2'b11, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0));

        // addi.
        step("addi_fetch",  0, ADDI, NOFN, 0, 1, vec(0, 3'b010, 0, 2'b01, 0, 0, 1, 0, 0, 0, 2'b00, 1, 0, 0));
        step("addi_decode", 0, ADDI, NOFN, 0, 1, vec(1, 3'b010, 0, 2'b11, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0));
        step("addi_exec",   0, ADDI, NOFN, 0, 1, vec(9, 3'b010, 1, 2'b10, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0));
        step("addi_wb",     0, ADDI, NOFN, 0, 1, vec(10, 3'b010, 0, 2'b00, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0, 0));

        // j.
        step("j_fetch",     0, JMP, NOFN, 0, 1, vec(0, 3'b010, 0, 2'b01, 0, 0, 1, 0, 0, 0, 2'b00, 1, 0, 0));
        step("j_decode",    0, JMP, NOFN, 0, 1, vec(1, 3'b010, 0, 2'b11, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0));
        step("j_exec",      0, JMP, NOFN, 0, 1, vec(11, 3'b010, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b10, 1, 0, 0));

        // R-type with an unsupported Funct is illegal.
        step("badfn_fetch", 0, RT, NOFN, 0, 1, vec(0, 3'b010, 0, 2'b01, 0, 0, 1, 0, 0, 0, 2'b00, 1, 0, 0));
        step("badfn_decode", 0, RT, NOFN, 0, 1, vec(1, 3'b010, 0, 2'b11, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0));

        // bne: branch-on-not-equal when enabled, illegal otherwise.
        step("bne_fetch",   0, BNE, NOFN, 0, 1, vec(0, 3'b010, 0, 2'b01, 0, 0, 1, 0, 0, 0, 2'b00, 1, 0, 0));
`ifdef SRG_CTRL_BNE_EN
        step("bne_decode",  0, BNE, NOFN, 0, 1, vec(1, 3'b010, 0, 2'b11, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0));
        step("bne_taken",   0, BNE, NOFN, 0, 1, vec(8, 3'b110, 1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b01, 1, 0, 0));
`else
        step("bne_illegal", 0, BNE, NOFN, 0, 1, vec(1, 3'b010, 0, 2'b11, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0));
`endif

        // Stall FETCH six cycles: flag rises after the fourth wait cycle and then sticks.
        for (int i = 0; i < 6; i++) begin
            step($sformatf("timeout_wait%0d", i), 0, SW, NOFN, 0, 0,
                 vec(0, 3'b010, 0, 2'b01, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, (i >= 4)));
        end
        @(negedge Clock);
        checks = checks + 1;
        if (MemTimeout !== 1'b1) begin
            failures = failures + 1;
            $display("[TB] FAIL timeout_expired: MemTimeout=%b after six wait cycles", MemTimeout);
        end
        step("timeout_release", 0, SW, NOFN, 0, 1, vec(0, 3'b010, 0, 2'b01, 0, 0, 1, 0, 0, 0, 2'b00, 1, 0, 1));
        step("timeout_sticky",  0, SW, NOFN, 0, 1, vec(1, 3'b010, 0, 2'b11, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1));
        step("abort_memadr",    0, SW, NOFN, 0, 1, vec(2, 3'b010, 1, 2'b10, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1));
        step("abort_memwr",     0, SW, NOFN, 0, 0, vec(5, 3'b010, 0, 2'b00, 1, 1, 0, 0, 0, 0, 2'b00, 0, 0, 1));

        // Reset mid-store: MemWrite suppressed at once, then FETCH with the flag cleared.
        step("abort_reset",     1, SW, NOFN, 0, 0, vec(5, 3'b010, 0, 2'b00, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1));
        step("after_abort",     0, RT, SLT, 0, 1, vec(0, 3'b010, 0, 2'b01, 0, 0, 1, 0, 0, 0, 2'b00, 1, 0, 0));
        step("after_decode",    0, RT, SLT, 0, 1, vec(1, 3'b010, 0, 2'b11, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0));

        @(posedge Clock);
        @(posedge Clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
